unit_a_seq: RTL and testbench

Parametrised, registered successor to the combinational 32-bit arithmetic unit.
- Executes the same arithmetic op codes (sum/sub/ainv/inc) plus logic ops, an iterative unsigned multiply and bit-serial shifts.
- Uses a start/busy/done handshake.
- Sits between the register file operand latches and the result write-back stage.
- Multi-cycle ops use a small FSM, so the datapath stays narrow.

---
 rtl/unit_a_seq.sv | 209 ++++++++++++++++++++
 tb/tb_unit_a_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/unit_a_seq.sv
// Registered arithmetic/logic unit with start/busy/done handshake; MUL and shifts iterate one step per cycle.
// Optional ARITH_SHIFT_EN macro adds SRA on op 1011 (otherwise 1011 is an unused code).
module unit_a_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       f,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             O,
  output logic             Z,
  output logic             N
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOTA = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_AINV = 4'b0110;
  localparam logic [3:0] OP_INC  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
`ifdef ARITH_SHIFT_EN
  localparam logic [3:0] OP_SRA  = 4'b1011;
`endif

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   ONE1 = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [3:0]         f_q;
  logic [SHAMT_W-1:0] n_q;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   acc;    // product high half
  logic [WIDTH-1:0]   wrk;    // multiplier / product low half, or shift value
  logic [WIDTH-1:0]   mcand;

  function automatic logic is_shift(input logic [3:0] op);
`ifdef ARITH_SHIFT_EN
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);
`else
    return (op == OP_SHL) || (op == OP_SHR);
`endif
  endfunction

  // Single-cycle result straight from the input operands.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_s;
  logic             sc_c, sc_o;

  always_comb begin
    sum  = '0;
    sc_s = '0;
    sc_c = 1'b0;
    sc_o = 1'b0;
    case (f)
      OP_AND:  sc_s = A & B;
      OP_OR:   sc_s = A | B;
      OP_XOR:  sc_s = A ^ B;
      OP_NOTA: sc_s = ~A;
      OP_ADD: begin
        sum  = {1'b0, A} + {1'b0, B};
        sc_s = sum[WIDTH-1:0];
        sc_c = sum[WIDTH];
        sc_o = (A[WIDTH-1] == B[WIDTH-1]) && (sc_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sum  = {1'b0, A} + {1'b0, ~B} + ONE1;
        sc_s = sum[WIDTH-1:0];
        sc_c = sum[WIDTH];
        sc_o = (A[WIDTH-1] != B[WIDTH-1]) && (sc_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AINV: begin
        sum  = {1'b0, ~A} + ONE1;
        sc_s = sum[WIDTH-1:0];
        sc_c = sum[WIDTH];
        sc_o = (A == SMIN);
      end
      OP_INC: begin
        sum  = {1'b0, A} + ONE1;
        sc_s = sum[WIDTH-1:0];
        sc_c = sum[WIDTH];
        sc_o = (A == ~SMIN);
      end
      default: begin
        // zero-amount shifts complete immediately with A unchanged
        if (is_shift(f)) sc_s = A;
      end
    endcase
  end

  logic multi;
  assign multi = (f == OP_MUL) || (is_shift(f) && (B[SHAMT_W-1:0] != '0));

  // One shift-add multiply step.
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] acc_nx, mq_nx;

  always_comb begin
    msum   = {1'b0, acc} + (wrk[0] ? {1'b0, mcand} : '0);
    acc_nx = msum[WIDTH:1];
    mq_nx  = {msum[0], wrk[WIDTH-1:1]};
  end

  // One shift step.
  logic [WIDTH-1:0] sh_nx;
  logic             sh_out;

  always_comb begin
    sh_nx  = {wrk[WIDTH-2:0], 1'b0};
    sh_out = wrk[WIDTH-1];
    if (f_q == OP_SHR) begin
      sh_nx  = {1'b0, wrk[WIDTH-1:1]};
      sh_out = wrk[0];
    end
`ifdef ARITH_SHIFT_EN
    else if (f_q == OP_SRA) begin
      sh_nx  = {wrk[WIDTH-1], wrk[WIDTH-1:1]};
      sh_out = wrk[0];
    end
`endif
  end

  logic             is_mul_q, last;
  logic [WIDTH-1:0] res_s;
  logic             res_c;

  assign is_mul_q = (f_q == OP_MUL);
  assign last     = is_mul_q ? (cnt == '1) : (cnt == n_q - 1'b1);
  assign res_s    = is_mul_q ? mq_nx : sh_nx;
  assign res_c    = is_mul_q ? (|acc_nx) : sh_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      c_out <= 1'b0;
      O     <= 1'b0;
      Z     <= 1'b0;
      N     <= 1'b0;
      f_q   <= '0;
      n_q   <= '0;
      cnt   <= '0;
      acc   <= '0;
      wrk   <= '0;
      mcand <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            f_q   <= f;
            n_q   <= B[SHAMT_W-1:0];
            cnt   <= '0;
            acc   <= '0;
            mcand <= A;
            wrk   <= (f == OP_MUL) ? B : A;
            if (multi) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done  <= 1'b1;
              S     <= sc_s;
              c_out <= sc_c;
              O     <= sc_o;
              Z     <= (sc_s == '0);
              N     <= sc_s[WIDTH-1];
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_mul_q) begin
            acc <= acc_nx;
            wrk <= mq_nx;
          end else begin
            wrk <= sh_nx;
          end
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            S     <= res_s;
            c_out <= res_c;
            O     <= 1'b0;
            Z     <= (res_s == '0);
            N     <= res_s[WIDTH-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unit_a_seq.sv
// Directed bench for unit_a_seq (WIDTH=32): arithmetic/logic ops, MUL, shifts, handshake and reset abort.
module tb_unit_a_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  f = '0;
  logic        busy, done, c_out, o_f, z_f, n_f;
  logic [31:0] s;

  int checks = 0;
  int errors = 0;

  unit_a_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .f(f),
    .busy(busy), .done(done), .S(s), .c_out(c_out), .O(o_f), .Z(z_f), .N(n_f)
  );

  always #5 clk = ~clk;

  // Issue one op and return the index of the edge (accept edge = 0) that raised done, or -1.
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output int lat);
    @(negedge clk);
    f = op; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (done) begin lat = k; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, s, c_out, o_f, z_f, n_f} !== 38'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", {busy, done, s, c_out, o_f, z_f, n_f});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Compare {S,c,O,Z,N} and latency for a list of single-cycle arithmetic vectors.
  task automatic test_arith();
    logic [3:0]  ops [8] = '{4'b0100, 4'b0101, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b0110, 4'b0111};
    logic [31:0] as  [8] = '{32'd6, 32'd6, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] bs  [8] = '{32'd6, 32'd6, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [35:0] exp [8] = '{{32'd12, 4'b0000}, {32'd0, 4'b1010}, {32'h80000000, 4'b0101},
                             {32'h80000000, 4'b0101}, {32'd0, 4'b1010}, {32'd0, 4'b1010},
                             {32'h80000000, 4'b0101}, {32'h80000000, 4'b0101}};
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], lat);
      checks++;
      if (lat !== 0) begin
        errors++;
        $display("FAIL arith%0d_latency got=%0d exp=0", i, lat);
      end
      checks++;
      if ({s, c_out, o_f, z_f, n_f} !== exp[i]) begin
        errors++;
        $display("FAIL arith%0d_result got=%h exp=%h", i, {s, c_out, o_f, z_f, n_f}, exp[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [3:0]  ops [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
    logic [35:0] exp [4] = '{{32'hF000F000, 4'b0001}, {32'hFFF0FFF0, 4'b0001},
                             {32'h0FF00FF0, 4'b0000}, {32'h0F0F0F0F, 4'b0000}};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'hF0F0F0F0, 32'hFF00FF00, lat);
      checks++;
      if (lat !== 0 || {s, c_out, o_f, z_f, n_f} !== exp[i]) begin
        errors++;
        $display("FAIL logic%0d got=%h lat=%0d exp=%h lat=0", i, {s, c_out, o_f, z_f, n_f}, lat, exp[i]);
      end
    end
    // unused code: S and carry/overflow/sign cleared
    run_op(4'b1111, 32'h12345678, 32'h9ABCDEF0, lat);
    checks++;
    if (lat !== 0 || {s, c_out, o_f, n_f} !== 35'd0) begin
      errors++;
      $display("FAIL unused_op got=%h lat=%0d exp=0 lat=0", {s, c_out, o_f, n_f}, lat);
    end
  endtask

  task automatic test_mul();
    int lat, bcnt;
    @(negedge clk);
    f = 4'b1000; a = 32'h00010000; b = 32'h00010001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; bcnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (k == 5) begin
        f = 4'b0100; a = 32'h1; b = 32'h1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin lat = k; break; end
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (lat !== 32) begin errors++; $display("FAIL mul_latency got=%0d exp=32", lat); end
    checks++;
    if (bcnt !== 32) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=32", bcnt); end
    checks++;
    if ({busy, s, c_out, o_f, z_f, n_f} !== {1'b0, 32'h00010000, 4'b1000}) begin
      errors++;
      $display("FAIL mul_result got=%h exp=%h", {busy, s, c_out, o_f, z_f, n_f}, {1'b0, 32'h00010000, 4'b1000});
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || s !== 32'h00010000) begin
      errors++;
      $display("FAIL mul_done_pulse_hold done=%b s=%h exp done=0 s=00010000", done, s);
    end
    run_op(4'b1000, 32'd3, 32'd5, lat);
    checks++;
    if (lat !== 32 || {s, c_out, o_f, z_f, n_f} !== {32'd15, 4'b0000}) begin
      errors++;
      $display("FAIL mul_small got=%h lat=%0d exp=%h lat=32", {s, c_out, o_f, z_f, n_f}, lat, {32'd15, 4'b0000});
    end
    run_op(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    checks++;
    if (lat !== 32 || {s, c_out, o_f, z_f, n_f} !== {32'd1, 4'b1000}) begin
      errors++;
      $display("FAIL mul_max got=%h lat=%0d exp=%h lat=32", {s, c_out, o_f, z_f, n_f}, lat, {32'd1, 4'b1000});
    end
  endtask

  task automatic test_shift();
    logic [3:0]  ops [5] = '{4'b1001, 4'b1001, 4'b1010, 4'b1010, 4'b1001};
    logic [31:0] as  [5] = '{32'h80000001, 32'h80000001, 32'h0000000F, 32'h80000000, 32'h00000001};
    logic [31:0] bs  [5] = '{32'd4, 32'd0, 32'd2, 32'h00000024, 32'd31};
    int          lx  [5] = '{4, 0, 2, 4, 31};
    logic [35:0] exp [5] = '{{32'h00000010, 4'b0000}, {32'h80000001, 4'b0001},
                             {32'h00000003, 4'b1000}, {32'h08000000, 4'b0000},
                             {32'h80000000, 4'b0001}};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], lat);
      checks++;
      if (lat !== lx[i]) begin
        errors++;
        $display("FAIL shift%0d_latency got=%0d exp=%0d", i, lat, lx[i]);
      end
      checks++;
      if ({s, c_out, o_f, z_f, n_f} !== exp[i]) begin
        errors++;
        $display("FAIL shift%0d_result got=%h exp=%h", i, {s, c_out, o_f, z_f, n_f}, exp[i]);
      end
    end
    run_op(4'b1011, 32'h80000000, 32'd4, lat);
`ifdef ARITH_SHIFT_EN
    checks++;
    if (lat !== 4 || {s, c_out, o_f, z_f, n_f} !== {32'hF8000000, 4'b0001}) begin
      errors++;
      $display("FAIL sra got=%h lat=%0d exp=%h lat=4", {s, c_out, o_f, z_f, n_f}, lat, {32'hF8000000, 4'b0001});
    end
`else
    checks++;
    if (lat !== 0 || {s, c_out, o_f, n_f} !== 35'd0) begin
      errors++;
      $display("FAIL op1011_unused got=%h lat=%0d exp=0 lat=0", {s, c_out, o_f, n_f}, lat);
    end
`endif
  endtask

  // A start presented in the done cycle is accepted.
  task automatic test_back_to_back();
    int lat;
    run_op(4'b0100, 32'd6, 32'd6, lat);
    f = 4'b0111; a = 32'h7FFFFFFF; b = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || {s, c_out, o_f, z_f, n_f} !== {32'h80000000, 4'b0101}) begin
      errors++;
      $display("FAIL back_to_back done=%b got=%h exp done=1 %h", done, {s, c_out, o_f, z_f, n_f}, {32'h80000000, 4'b0101});
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    int lat;
    run_op(4'b1000, 32'h00010000, 32'h00010001, lat);
    @(negedge clk);
    f = 4'b1000; a = 32'h0000FFFF; b = 32'h0000FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, s, c_out, o_f, z_f, n_f} !== 38'd0) begin
      errors++;
      $display("FAIL reset_abort_state got=%h exp=0", {busy, done, s, c_out, o_f, z_f, n_f});
    end
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0 || s !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort_no_done got=%0d s=%h exp=0 s=0", seen, s);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_mul();
    test_shift();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
